// File: rtl/conv_fifo_reader.sv
// Read side of the conv FIFO. Pops valid-pixel-position entries, decodes them
// into weight and membrane addresses, and presents one transaction per entry.
// Entries with an out-of-range kernel offset are dropped and counted. Every
// GROUP_SIZE consumed or dropped entries, group_done pulses.
//
// Handshake: a transaction transfers on any cycle where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0, w_addr, w_bank and
// mem_addr hold stable. out_ready while out_valid=0 has no effect.
module conv_fifo_reader #(
  parameter int CH_I_W     = 8,
  parameter int REL_W      = 4,
  parameter int CH_O_W     = 7,
  parameter int PX_W       = 2,
  parameter int KERNEL     = 3,
  parameter int W_ADDR_W   = 12,
  parameter int GROUP_SIZE = 4,
  parameter int CNT_W      = 16,
  localparam int ENTRY_W   = CH_I_W + REL_W + CH_O_W + 2 * PX_W,
  localparam int MEM_W     = CH_O_W + 2 * PX_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic [ENTRY_W-1:0]  dout,
  input  logic                empty,
  output logic                r_en,
  output logic [W_ADDR_W-1:0] w_addr,
  output logic [CH_O_W-1:0]   w_bank,
  output logic [MEM_W-1:0]    mem_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                group_done,
  output logic [CNT_W-1:0]    pkt_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [1:0]          state_dbg
);

  localparam int REL_HALF = REL_W / 2;
  localparam int GRP_W    = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
  localparam logic [REL_HALF-1:0] REL_MAX  = REL_HALF'(KERNEL - 1);
  localparam logic [W_ADDR_W-1:0] K_SQ     = W_ADDR_W'(KERNEL * KERNEL);
  localparam logic [W_ADDR_W-1:0] K_SIDE   = W_ADDR_W'(KERNEL);
  localparam logic [GRP_W-1:0]    GRP_LAST = GRP_W'(GROUP_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [W_ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [CH_O_W-1:0]     w_bank_q, w_bank_d;
  logic [MEM_W-1:0]      mem_addr_q, mem_addr_d;
  logic                  group_done_q, group_done_d;
  logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
  logic [GRP_W-1:0]      grp_cnt_q, grp_cnt_d;

  // Field split of the popped entry (valid while in RD_WAIT).
  logic [CH_I_W-1:0]   ch_i;
  logic [REL_HALF-1:0] rel_x, rel_y;
  logic [CH_O_W-1:0]   ch_o;
  logic [PX_W-1:0]     px_x, px_y;
  logic [W_ADDR_W-1:0] w_addr_calc;
  logic                malformed;
  logic                pop_ok;
  logic                grp_evt;

  assign {ch_i, rel_x, rel_y, ch_o, px_x, px_y} = dout;
  assign w_addr_calc = {{(W_ADDR_W - CH_I_W){1'b0}}, ch_i} * K_SQ
                     + {{(W_ADDR_W - REL_HALF){1'b0}}, rel_x} * K_SIDE
                     + {{(W_ADDR_W - REL_HALF){1'b0}}, rel_y};
  assign malformed   = (rel_x > REL_MAX) || (rel_y > REL_MAX);
  assign pop_ok      = rstn & enable & ~empty;

  // Next-state, pop strobe, decode and counter updates.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    w_addr_d     = w_addr_q;
    w_bank_d     = w_bank_q;
    mem_addr_d   = mem_addr_q;
    group_done_d = 1'b0;
    pkt_cnt_d    = pkt_cnt_q;
    err_cnt_d    = err_cnt_q;
    grp_cnt_d    = grp_cnt_q;
    grp_evt      = 1'b0;
    r_en         = 1'b0;
    case (state_q)
      IDLE: begin
        r_en = pop_ok;
        if (pop_ok) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        grp_evt = malformed;
        if (malformed) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
          state_d   = IDLE;
        end else begin
          w_addr_d    = w_addr_calc;
          w_bank_d    = ch_o;
          mem_addr_d  = {ch_o, px_x, px_y};
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_valid_q && out_ready) begin
          grp_evt     = 1'b1;
          pkt_cnt_d   = pkt_cnt_q + CNT_W'(1);
          out_valid_d = 1'b0;
          r_en        = pop_ok;
          state_d     = pop_ok ? RD_WAIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grp_evt) begin
      if (grp_cnt_q == GRP_LAST) begin
        grp_cnt_d    = '0;
        group_done_d = 1'b1;
      end else begin
        grp_cnt_d = grp_cnt_q + GRP_W'(1);
      end
    end
  end

  // State and registered outputs; reset discards any popped entry.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      w_addr_q     <= '0;
      w_bank_q     <= '0;
      mem_addr_q   <= '0;
      group_done_q <= 1'b0;
      pkt_cnt_q    <= '0;
      err_cnt_q    <= '0;
      grp_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      w_addr_q     <= w_addr_d;
      w_bank_q     <= w_bank_d;
      mem_addr_q   <= mem_addr_d;
      group_done_q <= group_done_d;
      pkt_cnt_q    <= pkt_cnt_d;
      err_cnt_q    <= err_cnt_d;
      grp_cnt_q    <= grp_cnt_d;
    end
  end

  assign w_addr     = w_addr_q;
  assign w_bank     = w_bank_q;
  assign mem_addr   = mem_addr_q;
  assign out_valid  = out_valid_q;
  assign group_done = group_done_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_conv_fifo_reader.sv
// Directed bench for conv_fifo_reader with a simple FIFO model on the read
// side. Inputs change and outputs are sampled on the falling clock edge.
module tb_conv_fifo_reader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [22:0] dout;
  logic        empty;
  logic        r_en;
  logic [11:0] w_addr;
  logic [6:0]  w_bank;
  logic [10:0] mem_addr;
  logic        out_valid;
  logic        out_ready;
  logic        group_done;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;
  logic [1:0]  state_dbg;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Clock / reset
  always #5 clk = ~clk;

  // FIFO model: registered read data, valid the cycle after r_en
  logic [22:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (r_en) begin
      dout   <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  conv_fifo_reader dut (
    .clk(clk), .rstn(rstn), .enable(enable), .dout(dout), .empty(empty),
    .r_en(r_en), .w_addr(w_addr), .w_bank(w_bank), .mem_addr(mem_addr),
    .out_valid(out_valid), .out_ready(out_ready), .group_done(group_done),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .state_dbg(state_dbg)
  );

  // Driver helpers
  function automatic logic [22:0] mk(input int ci, input int rx, input int ry,
                                     input int co, input int px, input int py);
    return {8'(ci), 2'(rx), 2'(ry), 7'(co), 2'(px), 2'(py)};
  endfunction

  task automatic push(input logic [22:0] e);
    mem[wr_ptr[7:0]] = e;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; enable = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Reset state
  task automatic test_reset();
    rstn = 1'b0; enable = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({out_valid, group_done, r_en, state_dbg} !== 5'b0) $display("FAIL reset_ctl got %b want 00000", {out_valid, group_done, r_en, state_dbg});
    else pass_cnt++;
    total_cnt++;
    if ({w_addr, w_bank, mem_addr} !== 30'd0) $display("FAIL reset_addr got %h want 0", {w_addr, w_bank, mem_addr});
    else pass_cnt++;
    total_cnt++;
    if ({pkt_cnt, err_cnt} !== 32'd0) $display("FAIL reset_cnt got %h want 0", {pkt_cnt, err_cnt});
    else pass_cnt++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // One entry, 2-cycle latency, out_ready held high beforehand
  task automatic test_single();
    do_reset();
    push(23'h2B039);
    enable = 1'b1; out_ready = 1'b1;
    #1;
    total_cnt++;
    if (r_en !== 1'b1) $display("FAIL single_ren got %b want 1", r_en);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({r_en, out_valid} !== 2'b00) $display("FAIL single_rdwait got %b want 00", {r_en, out_valid});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({out_valid, w_addr, w_bank, mem_addr} !== {1'b1, 12'd50, 7'd3, 11'd57})
      $display("FAIL single_out got v=%b wa=%0d wb=%0d ma=%0d want v=1 wa=50 wb=3 ma=57", out_valid, w_addr, w_bank, mem_addr);
    else pass_cnt++;
    total_cnt++;
    if (r_en !== 1'b0) $display("FAIL single_empty_out got r_en=%b want 0", r_en);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({out_valid, pkt_cnt, state_dbg} !== {1'b0, 16'd1, 2'd0}) $display("FAIL single_done got v=%b pkt=%0d st=%0d want 0 1 0", out_valid, pkt_cnt, state_dbg);
    else pass_cnt++;
  endtask

  // Four valid entries back to back, one group_done after the fourth
  task automatic test_group();
    logic [29:0] exp_q[$];
    int k;
    int gd_n;
    int gd_c;
    do_reset();
    push(mk(0, 0, 0, 0, 0, 0));     exp_q.push_back({12'd0,    7'd0,   11'd0});
    push(mk(255, 2, 2, 127, 3, 3)); exp_q.push_back({12'd2303, 7'd127, 11'd2047});
    push(mk(10, 2, 0, 64, 1, 2));   exp_q.push_back({12'd96,   7'd64,  11'd1030});
    push(mk(100, 0, 1, 5, 0, 3));   exp_q.push_back({12'd901,  7'd5,   11'd83});
    enable = 1'b1; out_ready = 1'b1;
    k = 0; gd_n = 0; gd_c = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL group_extra at cycle %0d want no transaction", c);
        else if ({w_addr, w_bank, mem_addr} !== exp_q[0] || c != 2 + 2 * k)
          $display("FAIL group_txn%0d got %h at cycle %0d want %h at cycle %0d", k, {w_addr, w_bank, mem_addr}, c, exp_q[0], 2 + 2 * k);
        else pass_cnt++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        k++;
      end
      if (group_done === 1'b1) begin gd_n++; gd_c = c; end
    end
    total_cnt++;
    if (gd_n != 1 || gd_c != 9) $display("FAIL group_done got %0d pulses at cycle %0d want 1 at 9", gd_n, gd_c);
    else pass_cnt++;
    total_cnt++;
    if (pkt_cnt !== 16'd4 || k != 4) $display("FAIL group_pkt got pkt=%0d txns=%0d want 4 4", pkt_cnt, k);
    else pass_cnt++;
  endtask

  // Held transaction under backpressure; second pop on the release cycle
  task automatic test_backpressure();
    int bad;
    do_reset();
    push(mk(7, 1, 1, 9, 1, 0));
    push(mk(3, 0, 2, 2, 2, 2));
    enable = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if ({out_valid, r_en, w_addr, w_bank, mem_addr} !== {1'b1, 1'b0, 12'd67, 7'd9, 11'd148}) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL bp_hold got %0d unstable cycles want 0 (last v=%b r_en=%b wa=%0d)", bad, out_valid, r_en, w_addr);
    else pass_cnt++;
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (r_en !== 1'b1) $display("FAIL bp_release_pop got r_en=%b want 1", r_en);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({out_valid, w_addr, w_bank, mem_addr, pkt_cnt} !== {1'b1, 12'd29, 7'd2, 11'd42, 16'd1})
      $display("FAIL bp_second got v=%b wa=%0d wb=%0d ma=%0d pkt=%0d want 1 29 2 42 1", out_valid, w_addr, w_bank, mem_addr, pkt_cnt);
    else pass_cnt++;
    @(negedge clk);
  endtask

  // Malformed second entry: dropped, counted, still part of the group
  task automatic test_malformed();
    int vmask;
    int gd_n;
    int gd_c;
    do_reset();
    push(mk(1, 0, 0, 1, 0, 0));
    push(mk(2, 3, 0, 2, 0, 0));
    push(mk(3, 1, 0, 3, 0, 0));
    push(mk(4, 2, 1, 4, 0, 0));
    enable = 1'b1; out_ready = 1'b1;
    vmask = 0; gd_n = 0; gd_c = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) vmask = vmask | (1 << c);
      if (group_done === 1'b1) begin gd_n++; gd_c = c; end
      if (c == 4) begin
        total_cnt++;
        if ({err_cnt, out_valid} !== {16'd1, 1'b0}) $display("FAIL mal_drop got err=%0d v=%b want 1 0", err_cnt, out_valid);
        else pass_cnt++;
      end
      if (c == 8) begin
        total_cnt++;
        if (w_addr !== 12'd43) $display("FAIL mal_last_addr got %0d want 43", w_addr);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (vmask != ((1 << 2) | (1 << 6) | (1 << 8))) $display("FAIL mal_valid_cycles got %h want %h", vmask, (1 << 2) | (1 << 6) | (1 << 8));
    else pass_cnt++;
    total_cnt++;
    if ({pkt_cnt, err_cnt} !== {16'd3, 16'd1} || gd_n != 1 || gd_c != 9)
      $display("FAIL mal_summary got pkt=%0d err=%0d gd=%0d@%0d want 3 1 1@9", pkt_cnt, err_cnt, gd_n, gd_c);
    else pass_cnt++;
  endtask

  // Drop of the group's last entry: err_cnt and group_done together
  task automatic test_drop_at_group_end();
    do_reset();
    push(mk(1, 0, 0, 1, 0, 0));
    push(mk(1, 1, 0, 1, 0, 0));
    push(mk(1, 2, 0, 1, 0, 0));
    push(mk(1, 0, 3, 1, 0, 0));
    enable = 1'b1; out_ready = 1'b1;
    repeat (7) @(negedge clk);
    total_cnt++;
    if ({group_done, err_cnt} !== {1'b0, 16'd0}) $display("FAIL dropend_before got gd=%b err=%0d want 0 0", group_done, err_cnt);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({group_done, err_cnt, pkt_cnt, out_valid} !== {1'b1, 16'd1, 16'd3, 1'b0})
      $display("FAIL dropend_same got gd=%b err=%0d pkt=%0d v=%b want 1 1 3 0", group_done, err_cnt, pkt_cnt, out_valid);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (group_done !== 1'b0) $display("FAIL dropend_pulse got gd=%b want 0", group_done);
    else pass_cnt++;
  endtask

  // enable gating in IDLE and while a transaction is held in OUT
  task automatic test_enable();
    int bad;
    do_reset();
    push(mk(6, 1, 1, 8, 3, 0));
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({r_en, state_dbg} !== 3'b000) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL en_low got %0d popping cycles want 0", bad);
    else pass_cnt++;
    push(mk(9, 0, 0, 1, 1, 1));
    enable = 1'b1;
    #1;
    total_cnt++;
    if (r_en !== 1'b1) $display("FAIL en_rise_pop got r_en=%b want 1", r_en);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({out_valid, w_addr} !== {1'b1, 12'd58}) $display("FAIL en_out got v=%b wa=%0d want 1 58", out_valid, w_addr);
    else pass_cnt++;
    enable = 1'b0; out_ready = 1'b1;
    #1;
    total_cnt++;
    if (r_en !== 1'b0) $display("FAIL en_drop_out got r_en=%b want 0", r_en);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({out_valid, r_en, pkt_cnt, state_dbg, empty} !== {1'b0, 1'b0, 16'd1, 2'd0, 1'b0})
      $display("FAIL en_drop_after got v=%b r_en=%b pkt=%0d st=%0d empty=%b want 0 0 1 0 0", out_valid, r_en, pkt_cnt, state_dbg, empty);
    else pass_cnt++;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    total_cnt++;
    if ({pkt_cnt, empty} !== {16'd2, 1'b1}) $display("FAIL en_drain got pkt=%0d empty=%b want 2 1", pkt_cnt, empty);
    else pass_cnt++;
  endtask

  // Reset while a transaction is held: popped entry lost, next decodes
  task automatic test_reset_mid_out();
    do_reset();
    push(mk(20, 1, 1, 10, 1, 1));
    push(mk(2, 2, 1, 6, 2, 3));
    enable = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL rst_mid_pre got v=%b want 1", out_valid);
    else pass_cnt++;
    rstn = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({out_valid, r_en, state_dbg, pkt_cnt, err_cnt, w_addr} !== {1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 12'd0})
      $display("FAIL rst_mid got v=%b r_en=%b st=%0d pkt=%0d err=%0d wa=%0d want all 0", out_valid, r_en, state_dbg, pkt_cnt, err_cnt, w_addr);
    else pass_cnt++;
    rstn = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({out_valid, w_addr, w_bank, mem_addr} !== {1'b1, 12'd25, 7'd6, 11'd107})
      $display("FAIL rst_mid_next got v=%b wa=%0d wb=%0d ma=%0d want 1 25 6 107", out_valid, w_addr, w_bank, mem_addr);
    else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_group();
    test_backpressure();
    test_malformed();
    test_drop_at_group_end();
    test_enable();
    test_reset_mid_out();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
